// File: rtl/rr_arb_n.sv
// N-requester round-robin arbiter with a bounded grant-hold window and a
// runtime fixed-priority mode; registered one-hot grant plus encoded index.
module rr_arb_n #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode_fixed,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    localparam int unsigned HW  = $clog2(MAX_HOLD + 1);
    localparam int unsigned IW1 = IDW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t         r_state, w_state;
    logic [N-1:0]   r_gnt, w_gnt;
    logic [IDW-1:0] r_gnt_id, w_gnt_id;
    logic [IDW-1:0] r_ptr, w_ptr;
    logic [HW-1:0]  r_hold, w_hold;

    logic           w_keep;
    logic [IDW-1:0] w_start;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_scan;
    logic           w_found;
    logic [IDW-1:0] w_pos;
    logic [IW1-1:0] w_sum;
    logic [IDW-1:0] w_win;

    // Rotate req so the scan start lands at bit 0, then find the lowest set bit.
    always_comb begin
        w_start = mode_fixed ? '0 : r_ptr;
        w_dbl   = {req, req} >> w_start;
        w_rot   = w_dbl[N-1:0];
        w_scan  = w_rot;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!w_found && w_scan[0]) begin
                w_found = 1'b1;
                w_pos   = IDW'(i);
            end
            w_scan = w_scan >> 1;
        end
        // Map the rotated position back to a requester index, wrapping at N.
        w_sum = {1'b0, w_start} + {1'b0, w_pos};
        if (w_sum >= IW1'(N)) begin
            w_sum = w_sum - IW1'(N);
        end
        w_win = w_sum[IDW-1:0];
    end

    // Next-state: keep the current owner inside its hold window, else re-arbitrate.
    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_gnt_id = r_gnt_id;
        w_ptr    = r_ptr;
        w_hold   = r_hold;
        w_keep   = (r_state == S_OWNED) && req[r_gnt_id]
                   && (r_hold != HW'(MAX_HOLD - 1));

        if (w_keep) begin
            w_hold = r_hold + HW'(1);
        end else if (w_found) begin
            w_state  = S_OWNED;
            w_gnt    = N'(1) << w_win;
            w_gnt_id = w_win;
            w_hold   = '0;
            w_ptr    = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
        end else begin
            w_state  = S_IDLE;
            w_gnt    = '0;
            w_gnt_id = '0;
            w_hold   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_gnt_id <= w_gnt_id;
            r_ptr    <= w_ptr;
            r_hold   <= w_hold;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = (r_state == S_OWNED);
    assign gnt_id    = r_gnt_id;

endmodule
